// File: rtl/status_led_pkg.sv
// Shared types for the status LED driver: mode codes,
// COUNT-mode FSM states, default tick length, width helper.
package status_led_pkg;

  localparam int TICK_CYC_DEF = 5000000;

  // 3'd6 and 3'd7 are reserved and decode as OFF
  typedef enum logic [2:0] {
    MODE_OFF   = 3'd0,
    MODE_ON    = 3'd1,
    MODE_SLOW  = 3'd2,
    MODE_FAST  = 3'd3,
    MODE_COUNT = 3'd4,
    MODE_PULSE = 3'd5
  } mode_e;

  typedef enum logic [1:0] {
    CS_IDLE = 2'd0,
    CS_ON   = 2'd1,
    CS_OFF  = 2'd2,
    CS_GAP  = 2'd3
  } cnt_st_e;

  // counter width able to hold 0..n-1, never zero
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/status_tick_gen.sv
// Free-running base-tick generator: counts 0..TICK_CYC-1.
// Ports: clk, reset_n (async, low), tick (1 clk at count end).
module status_tick_gen
  import status_led_pkg::*;
#(
  parameter int TICK_CYC = TICK_CYC_DEF
) (
  input  logic clk,
  input  logic reset_n,
  output logic tick
);

  localparam int TW = cw(TICK_CYC);
  localparam logic [TW-1:0] LAST = TW'(TICK_CYC - 1);

  logic [TW-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == LAST);

endmodule

// File: rtl/status_led_ctrl.sv
// Multi-channel status LED driver; per-channel runtime mode.
// Ports: clk, reset_n, status_en, cfg_we/ch/mode/count, event_in,
// led, tick; heartbeat only when STATUS_HEARTBEAT_EN is defined.
module status_led_ctrl
  import status_led_pkg::*;
#(
  parameter int TICK_CYC   = TICK_CYC_DEF,
  parameter int N_LED      = 6,
  parameter int SLOW_TICKS = 8,
  parameter int GAP_TICKS  = 4,
  parameter int CNT_W      = 4,
  localparam int CH_W      = cw(N_LED)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             status_en,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [2:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic [N_LED-1:0] event_in,
  output logic [N_LED-1:0] led,
  output logic             tick
`ifdef STATUS_HEARTBEAT_EN
  ,
  output logic             heartbeat
`endif
);

  localparam int SUB_MAX =
    (SLOW_TICKS > GAP_TICKS) ? SLOW_TICKS : GAP_TICKS;
  localparam int SUB_W = cw(SUB_MAX);
  localparam logic [SUB_W-1:0] SLOW_LD =
    SUB_W'(SLOW_TICKS - 1);
  localparam logic [SUB_W-1:0] GAP_LD =
    SUB_W'(GAP_TICKS - 1);

  status_tick_gen #(
    .TICK_CYC (TICK_CYC)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .tick    (tick)
  );

  for (genvar i = 0; i < N_LED; i++) begin : g_ch

    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    cnt_st_e          st_q, st_d;
    logic [SUB_W-1:0] sub_q, sub_d;
    logic             pend_q, pend_d;
    logic             prem_q, prem_d;
    logic             led_q, led_d;
    logic             wr_hit;
    logic             clr;

    // out-of-range channel numbers never match any i
    assign wr_hit = cfg_we && (cfg_ch == CH_W'(i));
    assign clr    = wr_hit || !status_en;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        mode_q <= MODE_OFF;
        cnt_q  <= '0;
        rem_q  <= '0;
        st_q   <= CS_IDLE;
        sub_q  <= '0;
        pend_q <= 1'b0;
        prem_q <= 1'b0;
        led_q  <= 1'b0;
      end else begin
        mode_q <= mode_d;
        cnt_q  <= cnt_d;
        rem_q  <= rem_d;
        st_q   <= st_d;
        sub_q  <= sub_d;
        pend_q <= pend_d;
        prem_q <= prem_d;
        led_q  <= led_d;
      end
    end

    always_comb begin
      mode_d = mode_q;
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      st_d   = st_q;
      sub_d  = sub_q;
      pend_d = pend_q;
      prem_d = prem_q;
      led_d  = led_q;
      if (wr_hit) begin
        mode_d = cfg_mode;
        cnt_d  = cfg_count;
      end
      // a write or disable wipes phase; a tick in the
      // same cycle is dropped for this channel
      if (clr) begin
        rem_d  = '0;
        st_d   = CS_IDLE;
        sub_d  = '0;
        pend_d = 1'b0;
        prem_d = 1'b0;
        led_d  = 1'b0;
      end else if (tick) begin
        case (mode_q)
          MODE_ON: led_d = 1'b1;
          MODE_SLOW: begin
            if (sub_q == '0) begin
              led_d = ~led_q;
              sub_d = SLOW_LD;
            end else begin
              sub_d = sub_q - 1'b1;
            end
          end
          MODE_FAST: led_d = ~led_q;
          MODE_COUNT: begin
            if (cnt_q == '0) begin
              st_d  = CS_IDLE;
              led_d = 1'b0;
            end else begin
              case (st_q)
                CS_IDLE: begin
                  st_d  = CS_ON;
                  led_d = 1'b1;
                  rem_d = cnt_q - 1'b1;
                end
                CS_ON: begin
                  st_d  = CS_OFF;
                  led_d = 1'b0;
                end
                CS_OFF: begin
                  if (rem_q != '0) begin
                    st_d  = CS_ON;
                    led_d = 1'b1;
                    rem_d = rem_q - 1'b1;
                  end else begin
                    st_d  = CS_GAP;
                    sub_d = GAP_LD;
                  end
                end
                CS_GAP: begin
                  if (sub_q == '0) begin
                    st_d  = CS_ON;
                    led_d = 1'b1;
                    rem_d = cnt_q - 1'b1;
                  end else begin
                    sub_d = sub_q - 1'b1;
                  end
                end
                default: st_d = CS_IDLE;
              endcase
            end
          end
          MODE_PULSE: begin
            // an event on the tick cycle starts from this tick
            if (pend_q || event_in[i]) begin
              led_d  = 1'b1;
              prem_d = 1'b1;
              pend_d = 1'b0;
            end else if (prem_q) begin
              prem_d = 1'b0;
            end else begin
              led_d = 1'b0;
            end
          end
          default: led_d = 1'b0;
        endcase
      end else if (mode_q == MODE_PULSE && event_in[i]) begin
        pend_d = 1'b1;
      end
    end

    assign led[i] = led_q;

  end

`ifdef STATUS_HEARTBEAT_EN
  localparam int HB_W = cw(SLOW_TICKS);
  localparam logic [HB_W-1:0] HB_LAST =
    HB_W'(SLOW_TICKS - 1);

  logic [HB_W-1:0] hb_cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hb_cnt_q  <= '0;
      heartbeat <= 1'b0;
    end else if (tick) begin
      if (hb_cnt_q == HB_LAST) begin
        hb_cnt_q  <= '0;
        heartbeat <= ~heartbeat;
      end else begin
        hb_cnt_q <= hb_cnt_q + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_status_led_ctrl.sv
// Directed testbench for status_led_ctrl (TICK_CYC=4,
// SLOW_TICKS=2, GAP_TICKS=4, N_LED=6).
module tb_status_led_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       status_en = 1'b0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_ch = '0;
  logic [2:0] cfg_mode = '0;
  logic [3:0] cfg_count = '0;
  logic [5:0] event_in = '0;
  logic [5:0] led;
  logic       tick;
`ifdef STATUS_HEARTBEAT_EN
  logic       heartbeat;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  status_led_ctrl #(
    .TICK_CYC   (4),
    .N_LED      (6),
    .SLOW_TICKS (2),
    .GAP_TICKS  (4),
    .CNT_W      (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .status_en (status_en),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_count (cfg_count),
    .event_in  (event_in),
    .led       (led),
    .tick      (tick)
`ifdef STATUS_HEARTBEAT_EN
    ,
    .heartbeat (heartbeat)
`endif
  );

  // return at the negedge just after the next tick edge
  task automatic next_tick;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (tick) begin
        @(negedge clk);
        return;
      end
    end
    checks++;
    errors++;
    $display("FAIL tick_timeout no tick in 20 clk");
  endtask

  // return at a negedge where tick is visible
  task automatic wait_tick_vis;
    for (int n = 0; n < 20; n++) begin
      if (tick) return;
      @(negedge clk);
    end
    checks++;
    errors++;
    $display("FAIL tick_vis_timeout no tick in 20 clk");
  endtask

  task automatic do_write(input logic [2:0] ch,
                          input logic [2:0] m,
                          input logic [3:0] c);
    cfg_we    = 1'b1;
    cfg_ch    = ch;
    cfg_mode  = m;
    cfg_count = c;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(negedge clk);
    checks++;
    if (led !== 6'b0) begin
      errors++;
      $display("FAIL rst_led got=%b exp=000000", led);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick got=%b exp=0", tick);
    end
    reset_n   = 1'b1;
    status_en = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 10);
    checks++;
    if (n !== 3) begin
      errors++;
      $display("FAIL first_tick got=%0d exp=3", n);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < 10);
    checks++;
    if (n !== 4) begin
      errors++;
      $display("FAIL tick_period got=%0d exp=4", n);
    end
    checks++;
    if (led !== 6'b0) begin
      errors++;
      $display("FAIL off_led got=%b exp=000000", led);
    end
  endtask

  task automatic test_fast_slow;
    int ef[6] = '{1, 0, 1, 0, 1, 0};
    int es[6] = '{1, 1, 0, 0, 1, 1};
    next_tick();
    do_write(3'd0, 3'd3, 4'd0);
    do_write(3'd1, 3'd2, 4'd0);
    checks++;
    if (led !== 6'b0) begin
      errors++;
      $display("FAIL fs_pre got=%b exp=000000", led);
    end
    for (int k = 0; k < 6; k++) begin
      next_tick();
      checks++;
      if (led[0] !== ef[k][0]) begin
        errors++;
        $display("FAIL fast_t%0d got=%b exp=%0d",
                 k + 1, led[0], ef[k]);
      end
      checks++;
      if (led[1] !== es[k][0]) begin
        errors++;
        $display("FAIL slow_t%0d got=%b exp=%0d",
                 k + 1, led[1], es[k]);
      end
    end
  endtask

  task automatic test_count;
    int ec[12] = '{1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, 0};
    next_tick();
    do_write(3'd2, 3'd4, 4'd3);
    for (int k = 0; k < 12; k++) begin
      next_tick();
      checks++;
      if (led[2] !== ec[k][0]) begin
        errors++;
        $display("FAIL count_t%0d got=%b exp=%0d",
                 k + 1, led[2], ec[k]);
      end
    end
  endtask

  task automatic test_pulse;
    int ep[3] = '{1, 1, 0};
    next_tick();
    do_write(3'd3, 3'd5, 4'd0);
    event_in[3] = 1'b1;
    @(negedge clk);
    event_in[3] = 1'b0;
    checks++;
    if (led[3] !== 1'b0) begin
      errors++;
      $display("FAIL pulse_pre got=%b exp=0", led[3]);
    end
    next_tick();
    checks++;
    if (led[3] !== 1'b1) begin
      errors++;
      $display("FAIL pulse_a got=%b exp=1", led[3]);
    end
    event_in[3] = 1'b1;
    @(negedge clk);
    event_in[3] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      next_tick();
      checks++;
      if (led[3] !== ep[k][0]) begin
        errors++;
        $display("FAIL pulse_ext%0d got=%b exp=%0d",
                 k, led[3], ep[k]);
      end
    end
    wait_tick_vis();
    event_in[3] = 1'b1;
    @(negedge clk);
    event_in[3] = 1'b0;
    checks++;
    if (led[3] !== 1'b1) begin
      errors++;
      $display("FAIL pulse_coin got=%b exp=1", led[3]);
    end
    for (int k = 1; k < 3; k++) begin
      next_tick();
      checks++;
      if (led[3] !== ep[k][0]) begin
        errors++;
        $display("FAIL pulse_coin%0d got=%b exp=%0d",
                 k, led[3], ep[k]);
      end
    end
  endtask

  task automatic test_enable;
    int ec[3] = '{1, 0, 1};
    logic [5:0] ev[3];
    ev[0] = 6'b000111;
    ev[1] = 6'b000010;
    ev[2] = 6'b000101;
    do_write(3'd2, 3'd4, 4'd3);
    for (int k = 0; k < 3; k++) begin
      next_tick();
      checks++;
      if (led[2] !== ec[k][0]) begin
        errors++;
        $display("FAIL en_burst%0d got=%b exp=%0d",
                 k, led[2], ec[k]);
      end
    end
    status_en = 1'b0;
    @(negedge clk);
    checks++;
    if (led !== 6'b0) begin
      errors++;
      $display("FAIL en_drop got=%b exp=000000", led);
    end
    for (int k = 0; k < 2; k++) begin
      next_tick();
      checks++;
      if (led !== 6'b0) begin
        errors++;
        $display("FAIL en_hold%0d got=%b exp=000000",
                 k, led);
      end
    end
    status_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_tick();
      checks++;
      if (led !== ev[k]) begin
        errors++;
        $display("FAIL en_re%0d got=%b exp=%b",
                 k + 1, led, ev[k]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [5:0] ev[8];
    ev[0] = 6'b000000;
    ev[1] = 6'b000111;
    ev[2] = 6'b000010;
    ev[3] = 6'b000000;
    ev[4] = 6'b000001;
    ev[5] = 6'b000010;
    ev[6] = 6'b000011;
    ev[7] = 6'b000100;
    do_write(3'd6, 3'd1, 4'd0);
    for (int k = 0; k < 3; k++) begin
      next_tick();
      checks++;
      if (led !== ev[k]) begin
        errors++;
        $display("FAIL badch_t%0d got=%b exp=%b",
                 k + 4, led, ev[k]);
      end
    end
    wait_tick_vis();
    do_write(3'd0, 3'd3, 4'd0);
    checks++;
    if (led !== ev[3]) begin
      errors++;
      $display("FAIL coin_t7 got=%b exp=%b", led, ev[3]);
    end
    for (int k = 4; k < 8; k++) begin
      next_tick();
      checks++;
      if (led !== ev[k]) begin
        errors++;
        $display("FAIL coin_t%0d got=%b exp=%b",
                 k + 4, led, ev[k]);
      end
    end
  endtask

  task automatic test_mid_reset;
    #1;
    reset_n = 1'b0;
    #1;
    checks++;
    if (led !== 6'b0) begin
      errors++;
      $display("FAIL midrst_led got=%b exp=000000", led);
    end
    checks++;
    if (tick !== 1'b0) begin
      errors++;
      $display("FAIL midrst_tick got=%b exp=0", tick);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_fast_slow();
    test_count();
    test_pulse();
    test_enable();
    test_back_to_back();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
